// File: rtl/bos_spi_target_emu_pkg.sv
// Shared frame geometry, FSM encodings and the default chip ID for the BOS SPI target emulator.
package bos_spi_target_emu_pkg;

  localparam int          FRAME_LEN   = 24;
  localparam int          SWAP_BIT    = 8;
  localparam int          ADDR_W      = 7;
  localparam logic [15:0] CHIP_ID_DEF = 16'hB05E;

  localparam logic [2:0] ST_WAIT_HI = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_CMD     = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_RD      = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/bos_spi_target_emu_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a history flop for edge detection.
module spi_pin_sync (
  input  logic clk,
  input  logic n_rst,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic hist;

  // Flops clear to 0 so a reset taken with cs_n low cannot fake an idle select.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = ~hist & sync;
  assign fall = hist & ~sync;

endmodule

// File: rtl/bos_spi_target_emu.sv
// SPI target emulating the BOS control register file: 24-bit frames, CPOL=1/CPHA=0, sdio turnaround
// after the 8-bit command. All pins are oversampled on sys_clk.
module bos_spi_target_emu
  import bos_spi_target_emu_pkg::*;
#(
  parameter int          N_REGS  = 8,
  parameter logic [15:0] CHIP_ID = CHIP_ID_DEF,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic                  sys_clk,
  input  logic                  n_rst,
  input  logic                  cs_n,
  input  logic                  sclk,
  input  logic                  sdio_i,
  output logic                  sdio_o,
  output logic                  sdio_oe,
  input  logic [15:0]           status_in,
  output logic [16*N_REGS-1:0]  reg_bus,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            abort_cnt
);

  localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic sdio_s, sdio_rise, sdio_fall;
  logic unused_sync;

  spi_pin_sync u_sync_cs   (.clk(sys_clk), .n_rst(n_rst), .pin(cs_n),
                            .sync(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_pin_sync u_sync_sclk (.clk(sys_clk), .n_rst(n_rst), .pin(sclk),
                            .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync u_sync_sdio (.clk(sys_clk), .n_rst(n_rst), .pin(sdio_i),
                            .sync(sdio_s), .rise(sdio_rise), .fall(sdio_fall));

  assign unused_sync = ^{sclk_s, sdio_rise, sdio_fall, cs_rise};

  logic [2:0]        state;
  logic [4:0]        bcnt;
  logic [15:0]       sr;
  logic [15:0]       sr_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [15:0]       shadow;
  logic [4:0]        out_cnt;
  logic              commit;
  logic              addr_ok;
  logic [15:0]       rd_val;
  logic [15:0]       regs [N_REGS];

  assign sr_nxt   = {sr[14:0], sdio_s};
  assign addr_nxt = sr_nxt[ADDR_W-1:0];
  assign addr_ok  = (int'(addr) >= 2) && (int'(addr) < N_REGS);

  // Value for the read shadow, decoded from the address as it completes on the 8th fall.
  always_comb begin
    rd_val = 16'h0000;
    if (addr_nxt == 7'd0)
      rd_val = CHIP_ID;
    else if (addr_nxt == 7'd1)
      rd_val = status_in;
    else if (int'(addr_nxt) < N_REGS)
      rd_val = regs[addr_nxt[IW-1:0]];
  end

  // cs_n high is checked before any sclk edge so a simultaneous edge always ends or aborts the frame.
  always_ff @(posedge sys_clk) begin
    if (!n_rst) begin
      state     <= ST_WAIT_HI;
      bcnt      <= 5'd0;
      sr        <= 16'h0000;
      addr      <= '0;
      shadow    <= 16'h0000;
      out_cnt   <= 5'd0;
      commit    <= 1'b0;
      sdio_o    <= 1'b0;
      sdio_oe   <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      abort_cnt <= 8'h00;
      for (int k = 0; k < N_REGS; k++)
        regs[k] <= (k < 2) ? 16'h0000 : RST_VAL;
    end else begin
      wr_stb <= 1'b0;
      commit <= 1'b0;
      if (commit && addr_ok) begin
        regs[addr[IW-1:0]] <= sr;
        wr_stb             <= 1'b1;
        wr_addr            <= addr;
      end
      if (cs_s) begin
        sdio_oe <= 1'b0;
        bcnt    <= 5'd0;
        out_cnt <= 5'd0;
      end
      case (state)
        ST_WAIT_HI: if (cs_s) state <= ST_IDLE;
        ST_IDLE:    if (cs_fall) state <= ST_CMD;
        ST_CMD, ST_WR, ST_RD: begin
          if (cs_s) begin
            state <= ST_IDLE;
            if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
          end else if (sclk_fall) begin
            bcnt <= bcnt + 5'd1;
            if (state != ST_RD) sr <= sr_nxt;
            if (state == ST_CMD && bcnt == 5'(SWAP_BIT - 1)) begin
              addr   <= addr_nxt;
              shadow <= rd_val;
              state  <= sr_nxt[ADDR_W] ? ST_RD : ST_WR;
            end else if (bcnt == 5'(FRAME_LEN - 1)) begin
              state  <= ST_DONE;
              commit <= (state == ST_WR);
            end
          end else if (sclk_rise && state == ST_RD && out_cnt < 5'd16) begin
            sdio_oe <= 1'b1;
            sdio_o  <= shadow[15];
            shadow  <= {shadow[14:0], 1'b0};
            out_cnt <= out_cnt + 5'd1;
          end
        end
        ST_DONE:    if (cs_s) state <= ST_IDLE;
        default:    state <= ST_WAIT_HI;
      endcase
    end
  end

  for (genvar k = 0; k < N_REGS; k++) begin : g_bus
    assign reg_bus[16*k +: 16] = regs[k];
  end

endmodule

// File: tb/tb_bos_spi_target_emu.sv
// Directed bench for bos_spi_target_emu: bit-banged SPI frames at sys_clk/8 with hand-computed results.
module tb_bos_spi_target_emu;

  logic         sys_clk = 1'b0;
  logic         n_rst   = 1'b0;
  logic         cs_n    = 1'b1;
  logic         sclk    = 1'b1;
  logic         sdio_i  = 1'b0;
  logic         sdio_o;
  logic         sdio_oe;
  logic [15:0]  status_in = 16'hA5C3;
  logic [127:0] reg_bus;
  logic         wr_stb;
  logic [6:0]   wr_addr;
  logic [7:0]   abort_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;
  logic [15:0] exp_regs [8];

  bos_spi_target_emu dut (
    .sys_clk(sys_clk), .n_rst(n_rst), .cs_n(cs_n), .sclk(sclk), .sdio_i(sdio_i),
    .sdio_o(sdio_o), .sdio_oe(sdio_oe), .status_in(status_in), .reg_bus(reg_bus),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .abort_cnt(abort_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (wr_stb === 1'b1) stb_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBus(input string tag);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("%s reg%0d", tag, k), {16'h0, reg_bus[16*k +: 16]}, {16'h0, exp_regs[k]});
  endtask

  // One select: drive nbits on sdio, sample the target just before every fall.
  task automatic applyStimulus(input logic [23:0] frame, input int nbits, input int rst_at,
                               output logic [23:0] rx, output int oe_early, output int oe_post,
                               output logic oe_end, output logic oe_after);
    rx = '0; oe_early = 0; oe_post = 0;
    @(negedge sys_clk); cs_n = 1'b0;
    repeat (8) @(negedge sys_clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        n_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_rst = 1'b1;
      end
      sdio_i = (i < 24) ? frame[23-i] : 1'b1;
      repeat (4) @(negedge sys_clk);
      if (sdio_oe === 1'b1) begin
        if (i < 8) oe_early++;
        if (i >= rst_at) oe_post++;
      end
      if (i < 24) rx[23-i] = sdio_o;
      sclk = 1'b0;
      repeat (4) @(negedge sys_clk);
      sclk = 1'b1;
    end
    repeat (8) @(negedge sys_clk);
    oe_end = sdio_oe;
    cs_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 oe_after = sdio_oe;
    repeat (10) @(negedge sys_clk);
  endtask

  initial begin
    logic [23:0] rx;
    int oe_early, oe_post, s0;
    logic oe_end, oe_after;

    for (int k = 0; k < 8; k++) exp_regs[k] = 16'h0000;
    repeat (5) @(negedge sys_clk);
    n_rst = 1'b1;
    repeat (5) @(negedge sys_clk);
    checkOutput("reset sdio_oe", {31'h0, sdio_oe}, 32'h0);
    checkOutput("reset wr_stb", {31'h0, wr_stb}, 32'h0);
    checkOutput("reset wr_addr", {25'h0, wr_addr}, 32'h0);
    checkOutput("reset abort_cnt", {24'h0, abort_cnt}, 32'h0);
    checkBus("reset");

    $display("[TB] write 0x05 <- 0x1234, read back");
    s0 = stb_cnt;
    applyStimulus(24'h051234, 24, -1, rx, oe_early, oe_post, oe_end, oe_after);
    exp_regs[5] = 16'h1234;
    checkOutput("wr05 stb pulses", stb_cnt - s0, 1);
    checkOutput("wr05 wr_addr", {25'h0, wr_addr}, 32'h5);
    checkBus("wr05");
    applyStimulus(24'h850000, 24, -1, rx, oe_early, oe_post, oe_end, oe_after);
    checkOutput("rd05 data", {16'h0, rx[15:0]}, 32'h1234);
    checkOutput("rd05 oe in cmd", oe_early, 0);
    checkOutput("rd05 oe bits", oe_post, 16);

    $display("[TB] read chip id and status");
    applyStimulus(24'h800000, 24, -1, rx, oe_early, oe_post, oe_end, oe_after);
    checkOutput("rd00 chip id", {16'h0, rx[15:0]}, 32'hB05E);
    checkOutput("rd00 oe in cmd", oe_early, 0);
    applyStimulus(24'h810000, 24, -1, rx, oe_early, oe_post, oe_end, oe_after);
    checkOutput("rd01 status", {16'h0, rx[15:0]}, 32'hA5C3);

    $display("[TB] out-of-range address");
    s0 = stb_cnt;
    applyStimulus(24'h7FFFFF, 24, -1, rx, oe_early, oe_post, oe_end, oe_after);
    checkOutput("wr7f no stb", stb_cnt - s0, 0);
    checkOutput("wr7f wr_addr kept", {25'h0, wr_addr}, 32'h5);
    checkBus("wr7f");
    applyStimulus(24'hFF0000, 24, -1, rx, oe_early, oe_post, oe_end, oe_after);
    checkOutput("rd7f zero", {16'h0, rx[15:0]}, 32'h0);

    $display("[TB] aborted write then full write to 0x03");
    s0 = stb_cnt;
    applyStimulus(24'h035555, 13, -1, rx, oe_early, oe_post, oe_end, oe_after);
    checkOutput("abort no stb", stb_cnt - s0, 0);
    checkOutput("abort count", {24'h0, abort_cnt}, 32'h1);
    checkBus("abort");
    s0 = stb_cnt;
    applyStimulus(24'h0300AA, 24, -1, rx, oe_early, oe_post, oe_end, oe_after);
    exp_regs[3] = 16'h00AA;
    checkOutput("wr03 stb", stb_cnt - s0, 1);
    checkOutput("wr03 wr_addr", {25'h0, wr_addr}, 32'h3);
    checkOutput("wr03 abort kept", {24'h0, abort_cnt}, 32'h1);
    checkBus("wr03");

    $display("[TB] reset in the middle of frames");
    applyStimulus(24'h800000, 24, 10, rx, oe_early, oe_post, oe_end, oe_after);
    for (int k = 0; k < 8; k++) exp_regs[k] = 16'h0000;
    checkOutput("rst rd oe after reset", oe_post, 0);
    checkOutput("rst abort cleared", {24'h0, abort_cnt}, 32'h0);
    checkOutput("rst wr_addr cleared", {25'h0, wr_addr}, 32'h0);
    checkBus("rst rd");
    s0 = stb_cnt;
    applyStimulus(24'h04BEEF, 24, 10, rx, oe_early, oe_post, oe_end, oe_after);
    checkOutput("rst wr no stb", stb_cnt - s0, 0);
    checkBus("rst wr");
    s0 = stb_cnt;
    applyStimulus(24'h065A5A, 24, -1, rx, oe_early, oe_post, oe_end, oe_after);
    exp_regs[6] = 16'h5A5A;
    checkOutput("post rst stb", stb_cnt - s0, 1);
    checkOutput("post rst wr_addr", {25'h0, wr_addr}, 32'h6);
    checkBus("post rst");

    $display("[TB] 30 bits per select");
    s0 = stb_cnt;
    applyStimulus(24'h07C3C3, 30, -1, rx, oe_early, oe_post, oe_end, oe_after);
    exp_regs[7] = 16'hC3C3;
    checkOutput("long wr stb", stb_cnt - s0, 1);
    checkOutput("long wr abort", {24'h0, abort_cnt}, 32'h0);
    checkBus("long wr");
    applyStimulus(24'h870000, 30, -1, rx, oe_early, oe_post, oe_end, oe_after);
    checkOutput("long rd data", {16'h0, rx[15:0]}, 32'hC3C3);
    checkOutput("long rd oe held", {31'h0, oe_end}, 32'h1);
    checkOutput("long rd oe drop", {31'h0, oe_after}, 32'h0);
    checkOutput("long rd abort", {24'h0, abort_cnt}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
